// File: rtl/ab_seq_tx.sv
// Two-wire {A,B} symbol transmitter: loads a frame, sends it rep+1 times
// with GAP_CYC idle cycles between copies, then pulses done.
module ab_seq_tx #(
  parameter int N_SYM   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic               clock,
  input  logic               RST,
  input  logic               ld,
  input  logic [2*N_SYM-1:0] frame,
  input  logic [1:0]         rep,
  output logic               A,
  output logic               B,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  localparam int IW = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_SYM - 1);
  localparam logic [3:0] GLAST = 4'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2*N_SYM-1:0] frame_q, frame_n;
  logic [IW-1:0] idx, idx_n;
  logic [3:0] gcnt, gcnt_n;
  logic [1:0] rcnt, rcnt_n;
  logic [1:0] sym;
  logic a_n, b_n, valid_n, busy_n, done_n;

  always_comb begin
    sym = frame_q[{idx, 1'b0} +: 2];
  end

  // Outputs are registered from the current state, so what the
  // state sees at an edge becomes visible on the pins after it.
  always_comb begin
    state_n = state;
    frame_n = frame_q;
    idx_n   = idx;
    gcnt_n  = gcnt;
    rcnt_n  = rcnt;
    a_n     = 1'b0;
    b_n     = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld) begin
          frame_n = frame;
          rcnt_n  = rep;
          idx_n   = '0;
          gcnt_n  = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        a_n     = sym[1];
        b_n     = sym[0];
        valid_n = 1'b1;
        busy_n  = 1'b1;
        if (idx == LAST) begin
          idx_n = '0;
          if (rcnt != 2'd0) begin
            rcnt_n  = rcnt - 2'd1;
            state_n = GAP;
          end else begin
            state_n = DONE;
          end
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gcnt == GLAST) begin
          gcnt_n  = '0;
          state_n = SEND;
        end else begin
          gcnt_n = gcnt + 4'd1;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (RST) begin
      state   <= IDLE;
      frame_q <= '0;
      idx     <= '0;
      gcnt    <= '0;
      rcnt    <= '0;
      A       <= 1'b0;
      B       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      frame_q <= frame_n;
      idx     <= idx_n;
      gcnt    <= gcnt_n;
      rcnt    <= rcnt_n;
      A       <= a_n;
      B       <= b_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_ab_seq_tx.sv
// Directed bench for ab_seq_tx: expected {A,B,valid,busy,done} per
// cycle are queued from a frame model and popped after each edge.
module tb_ab_seq_tx;

  localparam int N = 4;
  localparam int G = 1;

  logic clock = 1'b0;
  logic RST;
  logic ld;
  logic [2*N-1:0] frame;
  logic [1:0] rep;
  logic A, B, valid, busy, done;

  int checks = 0;
  int errors = 0;
  logic [4:0] expq[$];

  ab_seq_tx #(.N_SYM(N), .GAP_CYC(G)) dut (
    .clock (clock),
    .RST   (RST),
    .ld    (ld),
    .frame (frame),
    .rep   (rep),
    .A     (A),
    .B     (B),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  task automatic push(input logic [4:0] v);
    expq.push_back(v);
  endtask

  // Whole transmission after the load edge, plus one idle cycle.
  task automatic push_frame(input logic [2*N-1:0] f,
                            input logic [1:0] r);
    for (int c = 0; c <= int'(r); c++) begin
      for (int k = 0; k < N; k++)
        push({f[2*k+1], f[2*k], 3'b110});
      if (c < int'(r))
        for (int g = 0; g < G; g++)
          push(5'b00010);
    end
    push(5'b00001);
    push(5'b00000);
  endtask

  task automatic cyc(input string tag);
    logic [4:0] got;
    logic [4:0] exp;
    @(posedge clock);
    #1;
    got = {A, B, valid, busy, done};
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $error("FAIL %s: got %b expected <empty queue>", tag, got);
    end else begin
      exp = expq.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (expq.size() != 0 && guard < 200) begin
      cyc(tag);
      guard++;
    end
  endtask

  initial begin
    RST   = 1'b1;
    ld    = 1'b1;
    frame = 8'hFF;
    rep   = 2'd3;

    push(0); push(0);
    cyc("reset0"); cyc("reset1");
    RST = 1'b0;
    ld  = 1'b0;
    push(0); push(0);
    cyc("post_reset_idle0"); cyc("post_reset_idle1");

    frame = 8'b11_10_01_00;
    rep   = 2'd0;
    ld    = 1'b1;
    push(0);
    cyc("single_ld");
    ld = 1'b0;
    push_frame(8'b11_10_01_00, 2'd0);
    drain("single");

    frame = 8'b00_11_00_11;
    rep   = 2'd2;
    ld    = 1'b1;
    push(0);
    cyc("rep_ld");
    ld    = 1'b0;
    frame = 8'h00;
    rep   = 2'd0;
    push_frame(8'b00_11_00_11, 2'd2);
    drain("rep_gap");

    frame = 8'h1B;
    rep   = 2'd0;
    ld    = 1'b1;
    push(0);
    cyc("busy_ld0");
    ld = 1'b0;
    push_frame(8'h1B, 2'd0);
    cyc("busy_sym0");
    cyc("busy_sym1");
    ld    = 1'b1;
    frame = 8'hE4;
    rep   = 2'd3;
    cyc("busy_sym2");
    ld = 1'b0;
    drain("busy_ignore");

    frame = 8'h2D;
    rep   = 2'd1;
    ld    = 1'b1;
    push(0);
    cyc("abort_ld");
    ld = 1'b0;
    push({2'b01, 3'b110});
    push({2'b11, 3'b110});
    cyc("abort_sym0");
    cyc("abort_sym1");
    RST = 1'b1;
    push(0);
    cyc("abort_rst");
    RST = 1'b0;
    push(0); push(0); push(0);
    drain("abort_no_done");
    frame = 8'h96;
    rep   = 2'd0;
    ld    = 1'b1;
    push(0);
    cyc("abort_reload");
    ld = 1'b0;
    push_frame(8'h96, 2'd0);
    drain("abort_new");

    frame = 8'h4E;
    rep   = 2'd0;
    ld    = 1'b1;
    push(0);
    cyc("b2b_ld0");
    ld = 1'b0;
    for (int k = 0; k < N; k++)
      push({frame[2*k+1], frame[2*k], 3'b110});
    push(5'b00001);
    for (int i = 0; i < N + 1; i++)
      cyc("b2b_first");
    frame = 8'hB1;
    rep   = 2'd1;
    ld    = 1'b1;
    push(0);
    cyc("b2b_ld1");
    ld = 1'b0;
    push_frame(8'hB1, 2'd1);
    drain("b2b_second");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ab_seq_tx.md
# ab_seq_tx

Serial two-wire symbol transmitter. It drives the {A,B} input pair consumed by the two-input sequence-detector FSM. A frame of N_SYM two-bit symbols is loaded in parallel, emitted one symbol per clock on A/B, and optionally repeated with idle gap cycles between copies. The block is the stimulus/transmit end of the A,B interface and is used both on-chip and as a reusable bench driver.

## Interface
- N_SYM, default 4: symbols per frame (2..16).
- GAP_CYC, default 1: idle cycles between repeated frames (1..15).
- clock  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- ld  input  1  load/start strobe; sampled only in IDLE.
- frame  input  2*N_SYM  symbol payload; symbol k = frame[2k+1:2k], with A=bit 2k+1 and B=bit 2k; symbol 0 is sent first.
- rep  input  2  extra repeats; the frame is sent rep+1 times.
- A  output  1  symbol bit A (registered).
- B  output  1  symbol bit B (registered).
- valid  output  1  high while A/B carry a frame symbol.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse after the last symbol of the last copy.

## Operation
- Reset is synchronous and active-high on RST; the clock port is clock. At the first rising edge with RST=1: state=IDLE, A=B=valid=busy=done=0, internal frame and counters cleared. RST has priority over every other input.
- States:
  - IDLE: outputs 0. If ld=1, capture frame into a shift/holding register, capture rep into the repeat counter, clear the symbol index, and go to SEND.
  - SEND: A/B = symbol[idx], valid=1, busy=1. idx increments each cycle. After symbol N_SYM-1:
    - If the repeat counter is nonzero, decrement it and go to GAP.
    - Otherwise go to DONE.
  - GAP: A=B=valid=0, busy=1, for exactly GAP_CYC cycles. Then idx=0 and return to SEND.
  - DONE: done=1, busy=0, A=B=valid=0 for one cycle, then IDLE.
- ld in SEND, GAP or DONE is ignored. It is not queued, and frame/rep changes during transmission have no effect because the payload is captured at load.
- The symbol index is ceil(log2(N_SYM)) bits wide and is compared against N_SYM-1, never relying on wrap-around. The gap counter is 4 bits. The repeat counter is 2 bits and never underflows.
- RST asserted mid-frame aborts the frame: outputs are 0 from the next edge, no done pulse is produced, and the block returns to IDLE.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Take the ld-accepting edge as edge 0:
  - Symbol k of copy c (c=0..rep) is visible after edge 1 + c*(N_SYM+GAP_CYC) + k.
  - done is high after edge (rep+1)*N_SYM + rep*GAP_CYC + 1.
  - The block is back in IDLE one edge later.
  - The earliest next ld is accepted at edge (rep+1)*N_SYM + rep*GAP_CYC + 2.
- Per-copy behaviour:
  - valid is high for exactly N_SYM consecutive cycles per copy.
  - busy is high for (rep+1)*N_SYM + rep*GAP_CYC cycles in total.
- Simultaneous RST and ld: RST wins and the load is discarded.

## Test plan
- Reset: RST=1 for 2 cycles with ld=1 and frame=8'hFF. Required: A=B=valid=busy=done=0 throughout, and the block stays IDLE after RST drops with ld=0.
- Single frame (N_SYM=4, GAP_CYC=1): frame=8'b11_10_01_00, rep=0, ld pulsed for one cycle. Required:
  - AB = 00, 01, 10, 11 on cycles 1-4 with valid=1 and busy=1.
  - done=1 on cycle 5.
  - IDLE on cycle 6.
- Repeat with gap: frame=8'b00_11_00_11, rep=2. Required:
  - AB = 11, 00, 11, 00, then gap 00 with valid=0, repeated for three copies.
  - busy high for 14 cycles.
  - done on cycle 15.
- ld while busy: start frame=8'h1B, then pulse ld with frame=8'hE4 on cycle 2. Required: the sequence continues as 11, 10, 01, 00 (from 8'h1B) with no restart, and a single done pulse.
- Mid-frame reset: RST=1 on cycle 3 of a rep=1 transmission. Required:
  - Outputs are 0 from the next edge.
  - No done pulse.
  - A following ld transmits its new frame normally starting one cycle later.
- Back-to-back: ld asserted again in the first IDLE cycle after done. Required: the second frame's first symbol appears on the next cycle, with no extra dead cycles.
